// File: rtl/evt_burst_seq.sv
// -----------------------------------------------------------------------------
// evt_burst_seq
//   Multi-channel, event-triggered pulse-burst sequencer. Each channel waits
//   for a rising edge on its trigger, then emits single-cycle pulses separated
//   by a programmable gap. A burst is either counted (do-while: at least one
//   pulse) or runs forever until stopped.
//
//   Optional feature macro: EVT_BURST_SEQ_STATS_EN
//     adds stat_clr (input) and stat_pulses (output, 16 bits per channel),
//     a saturating per-channel count of pulse_out cycles.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   trig         per-channel trigger level, rising edge starts a burst
//   stop         per-channel level-sensitive abort
//   cfg_count    pulses per burst, channel i at [i*CNT_W +: CNT_W]
//   cfg_forever  per-channel repeat-until-stop select
//   cfg_gap      idle cycles between pulses (shared)
//   pulse_out    burst pulses
//   busy         channel not idle
//   done         1-cycle pulse when a counted burst completes normally
//   overrun      1-cycle pulse when a trigger edge arrives while busy
//   stat_clr     (stats build) per-channel synchronous counter clear
//   stat_pulses  (stats build) per-channel pulse counters
// -----------------------------------------------------------------------------
module evt_burst_seq #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH*CNT_W-1:0] cfg_count,
    input  logic [NUM_CH-1:0]       cfg_forever,
    input  logic [GAP_W-1:0]        cfg_gap,
`ifdef EVT_BURST_SEQ_STATS_EN
    input  logic [NUM_CH-1:0]       stat_clr,
    output logic [NUM_CH*16-1:0]    stat_pulses,
`endif
    output logic [NUM_CH-1:0]       pulse_out,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    logic [NUM_CH-1:0] trig_q_r;
    logic [NUM_CH-1:0] trig_edge_s;

    // Previous trigger level; resets to ones so a trigger held high through
    // reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q_r <= {NUM_CH{1'b1}};
        end else begin
            trig_q_r <= trig;
        end
    end

    assign trig_edge_s = trig & ~trig_q_r;

    // An edge seen while the channel is busy is dropped and flagged in the
    // same cycle it arrives, so this flag is decoded from the edge directly.
    assign overrun = trig_edge_s & busy;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_t           state_r, state_nxt_s;
        logic [CNT_W-1:0] rem_r, rem_nxt_s;
        logic             run_forever_r, run_forever_nxt_s;
        logic [GAP_W-1:0] gap_lat_r, gap_lat_nxt_s;
        logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
        logic             pulse_r, busy_r, done_r;
        logic [CNT_W-1:0] cfg_cnt_s;

        assign cfg_cnt_s = cfg_count[ch*CNT_W +: CNT_W];

        // Next-state and datapath decode for one channel.
        always_comb begin
            state_nxt_s       = state_r;
            rem_nxt_s         = rem_r;
            run_forever_nxt_s = run_forever_r;
            gap_lat_nxt_s     = gap_lat_r;
            gap_cnt_nxt_s     = gap_cnt_r;
            case (state_r)
                ST_IDLE: begin
                    if (trig_edge_s[ch] && !stop[ch]) begin
                        state_nxt_s       = ST_PULSE;
                        // A zero count still yields one pulse.
                        rem_nxt_s         = (cfg_cnt_s == CNT_ZERO) ? CNT_ONE : cfg_cnt_s;
                        run_forever_nxt_s = cfg_forever[ch];
                        gap_lat_nxt_s     = cfg_gap;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (stop[ch]) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        if (!run_forever_r && (rem_r <= CNT_ONE)) begin
                            state_nxt_s = ST_DONE;
                        end else if (gap_lat_r == GAP_ZERO) begin
                            state_nxt_s = ST_PULSE;
                        end else begin
                            state_nxt_s   = ST_GAP;
                            // GAP is left when the counter is zero, so load gap-1
                            // to stay exactly gap cycles.
                            gap_cnt_nxt_s = gap_lat_r - GAP_ONE;
                        end
                        // Forever bursts never touch rem; counted ones stop at zero.
                        if (!run_forever_r && (rem_r != CNT_ZERO)) begin
                            rem_nxt_s = rem_r - CNT_ONE;
                        end else begin
                            rem_nxt_s = rem_r;
                        end
                    end
                end
                ST_GAP: begin
                    if (stop[ch]) begin
                        state_nxt_s = ST_IDLE;
                    end else if (gap_cnt_r == GAP_ZERO) begin
                        state_nxt_s = ST_PULSE;
                    end else begin
                        gap_cnt_nxt_s = gap_cnt_r - GAP_ONE;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        // Channel state, datapath and registered Moore outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r       <= ST_IDLE;
                rem_r         <= CNT_ZERO;
                run_forever_r <= 1'b0;
                gap_lat_r     <= GAP_ZERO;
                gap_cnt_r     <= GAP_ZERO;
                pulse_r       <= 1'b0;
                busy_r        <= 1'b0;
                done_r        <= 1'b0;
            end else begin
                state_r       <= state_nxt_s;
                rem_r         <= rem_nxt_s;
                run_forever_r <= run_forever_nxt_s;
                gap_lat_r     <= gap_lat_nxt_s;
                gap_cnt_r     <= gap_cnt_nxt_s;
                pulse_r       <= (state_nxt_s == ST_PULSE);
                busy_r        <= (state_nxt_s != ST_IDLE);
                done_r        <= (state_nxt_s == ST_DONE);
            end
        end

        assign pulse_out[ch] = pulse_r;
        assign busy[ch]      = busy_r;
        assign done[ch]      = done_r;

`ifdef EVT_BURST_SEQ_STATS_EN
        logic [15:0] stat_r;

        // Saturating pulse counter; a clear request beats an increment.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stat_r <= 16'd0;
            end else if (stat_clr[ch]) begin
                stat_r <= 16'd0;
            end else if (pulse_r && (stat_r != 16'hFFFF)) begin
                stat_r <= stat_r + 16'd1;
            end else begin
                stat_r <= stat_r;
            end
        end

        assign stat_pulses[ch*16 +: 16] = stat_r;
`endif
    end

endmodule

// File: tb/tb_evt_burst_seq.sv
// -----------------------------------------------------------------------------
// tb_evt_burst_seq
//   Self-checking bench for evt_burst_seq. A behavioural model predicts each
//   channel's outputs from its burst start cycle with plain arithmetic; it is
//   compared every cycle. Directed table rows and hand-written sequences add
//   explicit expectations for the corner cases.
// -----------------------------------------------------------------------------
module tb_evt_burst_seq;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int GAP_W  = 4;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       trig;
    logic [NUM_CH-1:0]       stop;
    logic [NUM_CH*CNT_W-1:0] cfg_count;
    logic [NUM_CH-1:0]       cfg_forever;
    logic [GAP_W-1:0]        cfg_gap;
    logic [NUM_CH-1:0]       pulse_out;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH-1:0]       overrun;
`ifdef EVT_BURST_SEQ_STATS_EN
    logic [NUM_CH-1:0]       stat_clr;
    logic [NUM_CH*16-1:0]    stat_pulses;
`endif

    evt_burst_seq #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .GAP_W  (GAP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (trig),
        .stop        (stop),
        .cfg_count   (cfg_count),
        .cfg_forever (cfg_forever),
        .cfg_gap     (cfg_gap),
`ifdef EVT_BURST_SEQ_STATS_EN
        .stat_clr    (stat_clr),
        .stat_pulses (stat_pulses),
`endif
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model: per channel, whether a burst is active, the cycle
    // of its first pulse, its pulse count, gap and forever flag.
    bit                m_act   [NUM_CH];
    int                m_p0    [NUM_CH];
    int                m_n     [NUM_CH];
    int                m_g     [NUM_CH];
    bit                m_f     [NUM_CH];
    int                m_pcount[NUM_CH];
    logic [NUM_CH-1:0] m_tq;

    // Outputs as sampled in the most recent step.
    logic [NUM_CH-1:0] s_pulse, s_busy, s_done, s_ov;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_act[ch]    = 1'b0;
            m_p0[ch]     = 0;
            m_n[ch]      = 1;
            m_g[ch]      = 0;
            m_f[ch]      = 1'b0;
            m_pcount[ch] = 0;
        end
        m_tq = {NUM_CH{1'b1}};
        cyc  = 0;
    endtask

    // One clock cycle: inputs were driven just after the previous posedge;
    // compare at negedge, advance the model, then move past the next posedge.
    task automatic step();
        logic [NUM_CH-1:0] e_p, e_b, e_d, e_o;
        @(negedge clk);
        e_p = '0; e_b = '0; e_d = '0; e_o = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int rel, per, last;
            rel  = cyc - m_p0[ch];
            per  = m_g[ch] + 1;
            last = (m_n[ch] - 1) * per;
            if (m_act[ch]) begin
                e_b[ch] = 1'b1;
                if (m_f[ch]) begin
                    e_p[ch] = ((rel % per) == 0);
                end else begin
                    e_p[ch] = (rel <= last) && ((rel % per) == 0);
                    e_d[ch] = (rel == last + 1);
                end
            end
            e_o[ch] = trig[ch] & ~m_tq[ch] & m_act[ch];
        end
        s_pulse = pulse_out;
        s_busy  = busy;
        s_done  = done;
        s_ov    = overrun;
        check("model_pulse",   32'(pulse_out), 32'(e_p));
        check("model_busy",    32'(busy),      32'(e_b));
        check("model_done",    32'(done),      32'(e_d));
        check("model_overrun", 32'(overrun),   32'(e_o));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int rel, last;
            rel  = cyc - m_p0[ch];
            last = (m_n[ch] - 1) * (m_g[ch] + 1);
            if (m_act[ch]) begin
                if (stop[ch]) m_act[ch] = 1'b0;
                else if (!m_f[ch] && rel == last + 1) m_act[ch] = 1'b0;
            end else if (trig[ch] && !m_tq[ch] && !stop[ch]) begin
                m_act[ch] = 1'b1;
                m_p0[ch]  = cyc + 1;
                m_n[ch]   = (cfg_count[ch*CNT_W +: CNT_W] == '0) ? 1 : int'(cfg_count[ch*CNT_W +: CNT_W]);
                m_g[ch]   = int'(cfg_gap);
                m_f[ch]   = cfg_forever[ch];
            end
`ifdef EVT_BURST_SEQ_STATS_EN
            if (stat_clr[ch]) m_pcount[ch] = 0;
            else if (e_p[ch] && m_pcount[ch] < 65535) m_pcount[ch]++;
`else
            if (e_p[ch] && m_pcount[ch] < 65535) m_pcount[ch]++;
`endif
        end
        m_tq = trig;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pulse",   32'(pulse_out), 32'd0);
        check("reset_busy",    32'(busy),      32'd0);
        check("reset_done",    32'(done),      32'd0);
        check("reset_overrun", 32'(overrun),   32'd0);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [GAP_W-1:0] gap;
        logic [15:0]      p_mask;   // bit k: pulse k cycles after the edge cycle
        logic [15:0]      d_mask;
        logic [15:0]      b_mask;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cnt, ov, dn, bz;
        int dcyc [NUM_CH];
        rst_n       = 1'b0;
        trig        = '0;
        stop        = '0;
        cfg_count   = '0;
        cfg_forever = '0;
        cfg_gap     = '0;
`ifdef EVT_BURST_SEQ_STATS_EN
        stat_clr    = '0;
`endif
        tbl[0] = '{cnt: 8'd3, gap: 4'd2, p_mask: 16'h0092, d_mask: 16'h0100, b_mask: 16'h01FE};
        tbl[1] = '{cnt: 8'd0, gap: 4'd5, p_mask: 16'h0002, d_mask: 16'h0004, b_mask: 16'h0006};
        tbl[2] = '{cnt: 8'd4, gap: 4'd0, p_mask: 16'h001E, d_mask: 16'h0020, b_mask: 16'h003E};
        tbl[3] = '{cnt: 8'd1, gap: 4'd3, p_mask: 16'h0002, d_mask: 16'h0004, b_mask: 16'h0006};
        tbl[4] = '{cnt: 8'd2, gap: 4'd1, p_mask: 16'h000A, d_mask: 16'h0010, b_mask: 16'h001E};

        do_reset();
        step();

        // Directed single-burst rows on channel 0.
        for (int r = 0; r < 5; r++) begin
            cfg_count[CNT_W-1:0] = tbl[r].cnt;
            cfg_gap              = tbl[r].gap;
            trig[0]              = 1'b0;
            step();
            trig[0] = 1'b1;
            for (int k = 0; k < 16; k++) begin
                step();
                check($sformatf("tbl%0d_pulse_k%0d", r, k), 32'(s_pulse[0]), 32'(tbl[r].p_mask[k]));
                check($sformatf("tbl%0d_done_k%0d",  r, k), 32'(s_done[0]),  32'(tbl[r].d_mask[k]));
                check($sformatf("tbl%0d_busy_k%0d",  r, k), 32'(s_busy[0]),  32'(tbl[r].b_mask[k]));
            end
            trig[0] = 1'b0;
        end
        step();

        // Second edge during a burst: one overrun, burst unchanged.
        cfg_count[1*CNT_W +: CNT_W] = 8'd3;
        cfg_gap = 4'd2;
        cnt = 0; ov = 0; dn = 0;
        for (int k = 0; k < 14; k++) begin
            trig[1] = (k == 0) || (k >= 3);
            step();
            cnt += int'(s_pulse[1]);
            ov  += int'(s_ov[1]);
            dn  += int'(s_done[1]);
        end
        check("ovr_pulses", cnt, 3);
        check("ovr_count",  ov,  1);
        check("ovr_done",   dn,  1);
        trig[1] = 1'b0;
        step();

        // Forever burst, gap 1, stopped in a GAP cycle.
        cfg_forever[2] = 1'b1;
        cfg_gap        = 4'd1;
        trig[2]        = 1'b1;
        step();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cnt += int'(s_pulse[2]);
        end
        check("fev_pulses_20cyc", cnt, 10);
        step();
        check("fev_pulse_before_gap", 32'(s_pulse[2]), 32'd1);
        stop[2] = 1'b1;
        step();
        check("fev_gap_no_pulse", 32'(s_pulse[2]), 32'd0);
        check("fev_gap_busy",     32'(s_busy[2]),  32'd1);
        stop[2] = 1'b0;
        cnt = 0; dn = 0; bz = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            cnt += int'(s_pulse[2]);
            dn  += int'(s_done[2]);
            bz  += int'(s_busy[2]);
        end
        check("fev_stop_pulses", cnt, 0);
        check("fev_stop_done",   dn,  0);
        check("fev_stop_busy",   bz,  0);
        trig[2]        = 1'b0;
        cfg_forever[2] = 1'b0;
        step();

        // Edge and stop in the same idle cycle: stop wins.
        trig[3] = 1'b1;
        stop[3] = 1'b1;
        step();
        stop[3] = 1'b0;
        bz = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            bz += int'(s_busy[3]) + int'(s_pulse[3]);
        end
        check("edge_stop_no_burst", bz, 0);
        trig[3] = 1'b0;
        step();

        // All channels at once, counts 1..4, gap 1.
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cfg_count[ch*CNT_W +: CNT_W] = CNT_W'(ch + 1);
            dcyc[ch] = -1;
        end
        cfg_gap = 4'd1;
        trig    = '1;
        for (int k = 0; k < 12; k++) begin
            step();
            for (int ch = 0; ch < NUM_CH; ch++)
                if (s_done[ch]) dcyc[ch] = k;
        end
        for (int ch = 0; ch < NUM_CH; ch++)
            check($sformatf("all_done_ch%0d", ch), dcyc[ch], 2 * (ch + 1));
        trig = '0;
        step();

`ifdef EVT_BURST_SEQ_STATS_EN
        for (int ch = 0; ch < NUM_CH; ch++)
            check($sformatf("stat_ch%0d", ch), 32'(stat_pulses[ch*16 +: 16]), m_pcount[ch]);
        stat_clr = 4'b0001;
        step();
        stat_clr = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            check($sformatf("stat_clr_ch%0d", ch), 32'(stat_pulses[ch*16 +: 16]), m_pcount[ch]);
        check("stat_clr_zero", 32'(stat_pulses[15:0]), 32'd0);
`endif

        // Trigger held high across reset release: no burst.
        trig = '1;
        do_reset();
        bz = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            bz += int'(s_busy != '0);
        end
        check("held_trig_no_burst", bz, 0);
        trig = '0;

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if ($urandom_range(0, 7) == 0) trig[ch] = ~trig[ch];
                stop[ch]                     = ($urandom_range(0, 39) == 0);
                cfg_count[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
                cfg_forever[ch]              = ($urandom_range(0, 5) == 0);
            end
            cfg_gap = GAP_W'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/evt_burst_seq.md
Name: evt_burst_seq

Overview:
- Multi-channel, event-triggered pulse-burst sequencer. It is the synthesizable counterpart of procedural event-wait / do-while / forever loops.
- Each channel waits for a rising edge on its trigger, then emits a burst of single-cycle pulses separated by a programmable gap.
- A burst can be counted, with do-while semantics (always at least one pulse), or can run forever until stopped.
- The block sits between event sources (timers, status bits) and downstream strobe consumers.

Parameters:
- NUM_CH, 4: number of independent channels (1..32).
- CNT_W, 8: width of the per-channel pulse-count field.
- GAP_W, 4: width of the shared inter-pulse gap field.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- trig  input  NUM_CH  per-channel trigger level; the rising edge starts a burst.
- stop  input  NUM_CH  per-channel abort, level-sensitive.
- cfg_count  input  NUM_CH*CNT_W  pulses per burst; channel i uses bits [i*CNT_W +: CNT_W].
- cfg_forever  input  NUM_CH  1 means repeat until stop; cfg_count is ignored.
- cfg_gap  input  GAP_W  idle cycles between pulses, shared by all channels.
- pulse_out  output  NUM_CH  burst pulses.
- busy  output  NUM_CH  channel is not IDLE.
- done  output  NUM_CH  1-cycle pulse when a counted burst completes normally.
- overrun  output  NUM_CH  1-cycle pulse when a trigger edge arrives while the channel is busy.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; every channel FSM goes to IDLE; counters clear.
  - trig_q resets to all-ones, so a trigger already held high at reset release does NOT start a burst.
- Edge detect: edge[i] = trig[i] & ~trig_q[i]; trig_q is registered every cycle.
- Per-channel FSM states: IDLE, PULSE, GAP, DONE.
- IDLE:
  - On edge with stop low: latch cfg_count, cfg_forever and cfg_gap into channel registers, then go to PULSE.
  - First pulse_out appears in the cycle after the edge cycle.
- PULSE (1 cycle, pulse_out=1):
  - Remaining count rem decrements by 1.
  - A latched count of 0 is treated as 1: exactly one pulse (do-while).
  - Exit if not forever and this was the last pulse: go to DONE.
  - Exit otherwise, with gap=0: go to PULSE again (back-to-back pulses).
  - Exit otherwise, with gap>0: go to GAP.
- GAP: stays for exactly the latched gap cycles, with pulse_out=0, then goes to PULSE.
  - Pulse period is therefore gap+1 cycles.
- DONE (1 cycle): done=1, busy=1, then IDLE.
  - With the last pulse at cycle t: done at t+1, busy low at t+2.
  - The earliest new edge is accepted at t+2.
- busy = (state != IDLE); it goes high in the first PULSE cycle.
- stop:
  - In PULSE, GAP or DONE: the next state is IDLE. No done pulse, and no further pulse_out from the following cycle on.
  - In IDLE with a simultaneous edge: stop wins and no burst starts.
  - Stop is the only way a forever burst ends.
- Trigger edge while busy (PULSE, GAP or DONE):
  - Ignored; no queuing.
  - overrun=1 for that cycle.
  - The burst in progress is unaffected.
- Config changes while busy have no effect until the next start.
- Channels are fully independent; simultaneous starts on all channels are legal.
- Count arithmetic: rem is CNT_W bits, loaded with max(cfg_count,1), and never wraps.
- Gap counter: GAP_W bits, counting down to 0.

Optional Feature:
- Macro: EVT_BURST_SEQ_STATS_EN.
- When defined:
  - Adds output stat_pulses, NUM_CH*16 bits: per-channel count of pulse_out cycles.
  - Adds input stat_clr, NUM_CH bits: synchronous clear, which has priority over increment.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined: neither port exists and no counter logic is generated.

Test Plan:
- cfg_count=3, gap=2, trig rises at cycle 10:
  - pulse_out at 11, 14, 17; done at 18; busy high 11..18, low at 19.
- cfg_count=0, gap=5: exactly one pulse, one cycle after the edge; done on the following cycle.
- cfg_count=4, gap=0: four consecutive pulse_out cycles, then done.
- cfg_forever=1, gap=1:
  - Pulses every 2 cycles for 20 cycles.
  - stop asserted in a GAP cycle: busy low next cycle, no done, no further pulses.
- Overrun and independence:
  - Second trig edge during a burst: overrun pulses once and the burst count is unchanged.
  - trig held high across reset release: no burst.
  - Same-cycle edge+stop in IDLE: no burst.
- All NUM_CH channels triggered in the same cycle with different counts (1,2,3,4), gap=1: independent done timing.
- With EVT_BURST_SEQ_STATS_EN: stat_pulses equals the total pulses after the above; stat_clr zeroes only its own channel.
